i2c_txn_arbiter: RTL and testbench

- Shares one i2c_master instance between NREQ requesters.
- Arbitrates round-robin and latches the winner's address, data and rw.
- Sequences the master's start/stop handshake and supervises completion with a watchdog.
- Returns completion status and read data to the winning requester. Sits between on-chip clients (sensor pollers, config loaders) and the I2C master.

---
 rtl/i2c_txn_arbiter.sv | 164 ++++++++++++++++
 tb/tb_i2c_txn_arbiter.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_txn_arbiter.sv
// i2c_txn_arbiter: round-robin front end that shares one i2c_master
// between NREQ clients, sequencing start/stop under a watchdog.
module i2c_txn_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [7*NREQ-1:0] req_addr,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_rw,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic              status_ok,
  output logic              status_timeout,
  output logic [7:0]        rd_data,
  output logic              busy,
  output logic              m_start,
  output logic [6:0]        m_addr,
  output logic [7:0]        m_data,
  output logic              m_rw,
  output logic              m_stop,
  input  logic              m_ready,
  input  logic              m_fin_data,
  input  logic [7:0]        m_data_out
);

  localparam int IW = $clog2(NREQ);
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    ACCEPT,
    RUN,
    ABORT,
    DONE
  } state_t;

  state_t        state;
  logic [IW-1:0] last;
  logic [IW-1:0] win;
  logic [IW-1:0] pick;
  logic          found;
  logic [WW-1:0] wd;
  logic [WW-1:0] wd_next;
  logic          wd_hit;

  // Scan upward from the slot after the last winner, wrapping once.
  always_comb begin
    logic [IW:0] idx;
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = {1'b0, last} + (IW+1)'(k);
      if (idx >= (IW+1)'(NREQ)) begin
        idx = idx - (IW+1)'(NREQ);
      end
      if (!found && req[idx[IW-1:0]]) begin
        found = 1'b1;
        pick  = idx[IW-1:0];
      end
    end
  end

  assign wd_hit  = (wd == WD_LAST);
  assign wd_next = wd_hit ? wd : wd + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      grant          <= '0;
      done           <= '0;
      status_ok      <= 1'b0;
      status_timeout <= 1'b0;
      rd_data        <= '0;
      busy           <= 1'b0;
      m_start        <= 1'b0;
      m_addr         <= '0;
      m_data         <= '0;
      m_rw           <= 1'b0;
      m_stop         <= 1'b0;
      last           <= IW'(NREQ - 1);
      win            <= '0;
      wd             <= '0;
    end else begin
      m_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (found) begin
            win    <= pick;
            grant  <= NREQ'(1) << pick;
            busy   <= 1'b1;
            m_addr <= req_addr[7*pick +: 7];
            m_data <= req_data[8*pick +: 8];
            m_rw   <= req_rw[pick];
            wd     <= '0;
            state  <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (wd_hit) begin
            m_stop <= 1'b1;
            state  <= ABORT;
          end else if (m_ready) begin
            m_start <= 1'b1;
            wd      <= '0;
            state   <= ACCEPT;
          end else begin
            wd <= wd_next;
          end
        end
        ACCEPT: begin
          if (wd_hit) begin
            m_stop <= 1'b1;
            state  <= ABORT;
          end else begin
            wd <= wd_next;
            if (!m_ready) begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (wd_hit) begin
            m_stop <= 1'b1;
            state  <= ABORT;
          end else if (m_ready) begin
            done           <= grant;
            rd_data        <= m_data_out;
            status_ok      <= m_fin_data;
            status_timeout <= 1'b0;
            state          <= DONE;
          end else begin
            wd <= wd_next;
          end
        end
        ABORT: begin
          // Ready is only trusted once the stop pulse has gone out.
          m_stop <= 1'b0;
          if (!m_stop && m_ready) begin
            done           <= grant;
            rd_data        <= m_data_out;
            status_ok      <= 1'b0;
            status_timeout <= 1'b1;
            state          <= DONE;
          end
        end
        DONE: begin
          done  <= '0;
          grant <= '0;
          busy  <= 1'b0;
          last  <= win;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Bench for i2c_txn_arbiter: table vectors, corner sequences and
// randomized traffic against a behavioural master and arbiter model.
module tb_i2c_txn_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req = '0;
  logic [7*N-1:0] req_addr = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_rw = '0;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           status_ok;
  logic           status_timeout;
  logic [7:0]     rd_data;
  logic           busy;
  logic           m_start;
  logic [6:0]     m_addr;
  logic [7:0]     m_data;
  logic           m_rw;
  logic           m_stop;
  logic           m_ready = 1'b1;
  logic           m_fin_data = 1'b0;
  logic [7:0]     m_data_out = '0;

  i2c_txn_arbiter #(.NREQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req(req), .req_addr(req_addr),
    .req_data(req_data), .req_rw(req_rw),
    .grant(grant), .done(done),
    .status_ok(status_ok),
    .status_timeout(status_timeout),
    .rd_data(rd_data), .busy(busy),
    .m_start(m_start), .m_addr(m_addr),
    .m_data(m_data), .m_rw(m_rw),
    .m_stop(m_stop), .m_ready(m_ready),
    .m_fin_data(m_fin_data),
    .m_data_out(m_data_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at cyc", nm, act, exp);
    end
  endtask

  // Requester inputs as seen by the DUT at the last rising edge.
  int             cyc = 0;
  logic [N-1:0]   req_q;
  logic [7*N-1:0] addr_q;
  logic [8*N-1:0] data_q;
  logic [N-1:0]   rw_q;
  always @(posedge clk) begin
    req_q  = req;
    addr_q = req_addr;
    data_q = req_data;
    rw_q   = req_rw;
    cyc++;
  end

  typedef struct {
    logic       ok;
    logic       to;
    logic [7:0] rd;
  } res_t;
  res_t resq[$];

  // Behavioural i2c_master: accepts start, works for mcnt cycles,
  // or hangs until stop, then returns to ready.
  logic       rnd_mode = 1'b0;
  int         cfg_lat = 2;
  logic       cfg_fin = 1'b1;
  logic       cfg_hang = 1'b0;
  logic [7:0] cfg_dout = '0;
  logic       mbusy = 1'b0;
  logic       mhang = 1'b0;
  logic       mfin = 1'b0;
  logic       aborted = 1'b0;
  logic [7:0] mdout = '0;
  int         mcnt = 0;
  int         mhold = 0;
  int         n_start = 0;
  int         n_stop = 0;
  int         start_cyc = 0;
  int         stop_cyc = 0;

  always @(negedge clk) begin
    if (!reset) begin
      m_ready = 1'b1;
      m_fin_data = 1'b0;
      m_data_out = '0;
      mbusy = 1'b0;
      mhold = 0;
    end else begin
      if (m_start) begin n_start++; start_cyc = cyc; end
      if (m_stop) begin n_stop++; stop_cyc = cyc; end
      if (!mbusy) begin
        if (m_start) begin
          mbusy = 1'b1;
          m_ready = 1'b0;
          aborted = 1'b0;
          if (rnd_mode) begin
            mcnt = $urandom_range(1, 6);
            mfin = 1'($urandom);
            mdout = 8'($urandom);
            mhang = ($urandom % 8 == 0);
          end else begin
            mcnt = cfg_lat;
            mfin = cfg_fin;
            mdout = cfg_dout;
            mhang = cfg_hang;
          end
        end else if (mhold > 0) begin
          m_ready = 1'b0;
          mhold--;
        end else begin
          m_ready = 1'b1;
          if (rnd_mode && $urandom % 8 == 0) mhold = $urandom_range(1, 3);
        end
      end else if (m_stop) begin
        aborted = 1'b1;
        mhang = 1'b0;
        mcnt = 2;
      end else if (!mhang) begin
        if (mcnt <= 1) begin
          mbusy = 1'b0;
          m_ready = 1'b1;
          m_fin_data = mfin;
          m_data_out = mdout;
          resq.push_back('{(aborted ? 1'b0 : mfin), aborted, mdout});
        end else begin
          mcnt--;
        end
      end
    end
  end

  // Transaction monitor with a round-robin reference.
  int         last_w = N - 1;
  int         cur_w = 0;
  int         n_done = 0;
  int         d_cyc = -1;
  logic [N-1:0] gprev = '0;
  logic [6:0] e_addr;
  logic [7:0] e_data;
  logic       e_rw;
  int         win_log[$];
  int         gap_log[$];

  always @(negedge clk) begin
    if (!reset) begin
      last_w = N - 1;
      gprev = '0;
      d_cyc = -1;
      resq.delete();
    end else begin
      if (grant != '0 && gprev == '0) begin
        int ew;
        ew = -1;
        for (int k = 1; k <= N; k++) begin
          int j;
          j = (last_w + k) % N;
          if (ew < 0 && req_q[j]) ew = j;
        end
        chk("arb_winner", grant, (ew < 0) ? 0 : (1 << ew));
        if (ew >= 0) begin
          cur_w = ew;
          e_addr = addr_q[7*ew +: 7];
          e_data = data_q[8*ew +: 8];
          e_rw = rw_q[ew];
        end
        win_log.push_back(ew);
        if (d_cyc >= 0) gap_log.push_back(cyc - d_cyc);
      end
      chk("busy_vs_grant", busy, grant != '0);
      if (m_start) begin
        chk("m_addr", m_addr, e_addr);
        chk("m_data", m_data, e_data);
        chk("m_rw", m_rw, e_rw);
      end
      if (done != '0) begin
        n_done++;
        d_cyc = cyc;
        chk("done_winner", done, 1 << cur_w);
        chk("pending_results", resq.size(), 1);
        if (resq.size() > 0) begin
          res_t r;
          r = resq.pop_front();
          chk("status_ok", status_ok, r.ok);
          chk("status_timeout", status_timeout, r.to);
          chk("rd_data", rd_data, r.rd);
        end
        last_w = cur_w;
      end
      gprev = grant;
    end
  end

  task automatic set_req(input int i, input logic [6:0] a,
                         input logic [7:0] d, input logic rw);
    req_addr[7*i +: 7] = a;
    req_data[8*i +: 8] = d;
    req_rw[i] = rw;
    req[i] = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int i, input int budget);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (done[i]) break;
    end
    #1;
    chk("wait_done", done, 1 << i);
  endtask

  task automatic wait_any_done(input int budget);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (done != '0) break;
    end
    #1;
    chk("wait_any_done", done != '0, 1);
  endtask

  typedef struct {
    int         who;
    logic [6:0] a;
    logic [7:0] d;
    logic       rw;
    int         lat;
    logic       fin;
    logic       hang;
    logic [7:0] dout;
    logic       eok;
    logic       eto;
    logic [7:0] erd;
  } vec_t;

  vec_t tv[4];
  int   exp_order[6];

  initial begin : main
    int s0, p0, nd0;
    tv[0] = '{0, 7'h50, 8'hA5, 1'b1, 3, 1'b1, 1'b0, 8'h00,
              1'b1, 1'b0, 8'h00};
    tv[1] = '{1, 7'h21, 8'h00, 1'b0, 4, 1'b0, 1'b0, 8'h3C,
              1'b0, 1'b0, 8'h3C};
    tv[2] = '{2, 7'h68, 8'h5A, 1'b1, 2, 1'b1, 1'b1, 8'hE7,
              1'b0, 1'b1, 8'hE7};
    tv[3] = '{3, 7'h7F, 8'hFF, 1'b0, 1, 1'b1, 1'b0, 8'h81,
              1'b1, 1'b0, 8'h81};
    exp_order = '{0, 1, 2, 3, 0, 1};

    repeat (3) @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ok", status_ok, 0);
    chk("rst_to", status_timeout, 0);
    chk("rst_rd", rd_data, 0);
    chk("rst_start", m_start, 0);
    chk("rst_addr", m_addr, 0);
    chk("rst_data", m_data, 0);
    chk("rst_rw", m_rw, 0);
    chk("rst_stop", m_stop, 0);
    @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    #1;

    for (int v = 0; v < 4; v++) begin
      cfg_lat = tv[v].lat;
      cfg_fin = tv[v].fin;
      cfg_hang = tv[v].hang;
      cfg_dout = tv[v].dout;
      s0 = n_start;
      p0 = n_stop;
      set_req(tv[v].who, tv[v].a, tv[v].d, tv[v].rw);
      wait_done(tv[v].who, 200);
      chk("vec_ok", status_ok, tv[v].eok);
      chk("vec_to", status_timeout, tv[v].eto);
      chk("vec_rd", rd_data, tv[v].erd);
      chk("vec_addr", m_addr, tv[v].a);
      chk("vec_data", m_data, tv[v].d);
      chk("vec_rw", m_rw, tv[v].rw);
      chk("vec_starts", n_start - s0, 1);
      chk("vec_stops", n_stop - p0, tv[v].hang);
      if (tv[v].hang) chk("wd_cycles", stop_cyc - start_cyc, TO);
      req[tv[v].who] = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("vec_idle", busy, 0);
    end

    // Simultaneous requests 0 and 2 right after reset.
    do_reset();
    cfg_lat = 2;
    cfg_hang = 1'b0;
    win_log.delete();
    s0 = n_start;
    set_req(0, 7'h11, 8'h22, 1'b1);
    set_req(2, 7'h33, 8'h44, 1'b0);
    wait_done(0, 100);
    req[0] = 1'b0;
    wait_done(2, 100);
    req[2] = 1'b0;
    chk("pair_count", win_log.size(), 2);
    if (win_log.size() == 2) begin
      chk("pair_first", win_log[0], 0);
      chk("pair_second", win_log[1], 2);
    end
    chk("pair_starts", n_start - s0, 2);

    // All four held high across six transactions.
    do_reset();
    win_log.delete();
    gap_log.delete();
    for (int i = 0; i < N; i++) set_req(i, 7'(8 + i), 8'(16 * i), 1'(i));
    for (int t = 0; t < 6; t++) wait_any_done(100);
    req = '0;
    chk("rr_count", win_log.size(), 6);
    for (int t = 0; t < 6 && t < win_log.size(); t++) begin
      chk("rr_order", win_log[t], exp_order[t]);
    end
    chk("gap_count", gap_log.size(), 5);
    foreach (gap_log[g]) chk("rr_gap", gap_log[g], 2);
    repeat (3) @(negedge clk);

    // Asynchronous reset while the master is busy in RUN.
    cfg_lat = 10;
    set_req(0, 7'h45, 8'h67, 1'b1);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (m_start) break;
    end
    chk("start_seen", m_start, 1);
    repeat (3) @(negedge clk);
    chk("run_busy", busy, 1);
    nd0 = n_done;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_grant", grant, 0);
    chk("arst_busy", busy, 0);
    chk("arst_start", m_start, 0);
    chk("arst_stop", m_stop, 0);
    req[0] = 1'b0;
    set_req(3, 7'h0C, 8'h3E, 1'b0);
    cfg_lat = 2;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (grant != '0) break;
    end
    #1;
    chk("post_rst_grant", grant, 4'b1000);
    chk("no_done_reset", n_done, nd0);
    wait_done(3, 100);
    req[3] = 1'b0;
    repeat (2) @(negedge clk);

    // Randomized traffic.
    rnd_mode = 1'b1;
    nd0 = n_done;
    for (int c = 0; c < 4000 && n_done - nd0 < 40; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          if (done[i] ? ($urandom % 2 == 0) : ($urandom % 16 == 0)) begin
            req[i] = 1'b0;
          end else if (done[i]) begin
            set_req(i, 7'($urandom), 8'($urandom), 1'($urandom));
          end
        end else if ($urandom % 4 == 0) begin
          set_req(i, 7'($urandom), 8'($urandom), 1'($urandom));
        end
      end
    end
    req = '0;
    chk("rnd_txns", n_done - nd0 >= 40, 1);
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("drain_idle", busy, 0);
    rnd_mode = 1'b0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : guard
    #600000;
    n_bad++;
    $display("FAIL global_timeout: got running want finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
